// File: rtl/enemy_pkg.sv
// enemy_pkg: shared screen geometry, control-word layout and spawner state encoding.
package enemy_pkg;
    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int START_LSB = 0;
    localparam int START_W = 10;
    localparam int FLIP_BIT = 10;
    localparam int SPEED_LSB = 11;
    localparam int SPEED_W = 2;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef logic [15:0] ctrl_word_t;
    typedef enum logic [1:0] {IDLE, RAMP, RUN} spawn_state_t;

    function automatic ctrl_word_t make_word(input logic [1:0] lvl, input logic [10:0] rnd);
        return {3'b000, lvl, rnd[FLIP_BIT], rnd[START_W-1:0]};
    endfunction
endpackage

// File: rtl/lfsr16.sv
// lfsr16: 16-bit right-shifting Galois LFSR; a zero seed is replaced by 1 so it never locks up.
module lfsr16 import enemy_pkg::*; #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        frame_clk,
    input  logic        rst,
    input  logic        adv,
    output logic [15:0] q,
    output logic [15:0] q_nx
);
    localparam logic [15:0] INIT = (SEED == 16'h0000) ? 16'h0001 : SEED;

    assign q_nx = {1'b0, q[15:1]} ^ (q[0] ? LFSR_TAPS : 16'h0000);

    always_ff @(posedge frame_clk or negedge rst)
        if (!rst) q <= INIT;
        else if (adv) q <= q_nx;
endmodule

// File: rtl/enemy_spawner.sv
// enemy_spawner: staggers enemy releases, refreshes control words round-robin from an LFSR
// and raises the difficulty level on a frame timer.
module enemy_spawner import enemy_pkg::*; #(
    parameter int N_ENEMIES = 4,
    parameter int SPAWN_INTERVAL = 60,
    parameter int LEVEL_FRAMES = 600,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                   frame_clk,
    input  logic                   rst,
    input  logic                   run,
    input  logic                   pause,
    output logic [16*N_ENEMIES-1:0] enemy_control,
    output logic [N_ENEMIES-1:0]   enemy_en,
    output logic [1:0]             level,
    output logic                   all_released
);
    localparam int CW = $clog2(SPAWN_INTERVAL + 1);
    localparam int LW = $clog2(LEVEL_FRAMES + 1);

    spawn_state_t state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [LW-1:0] ltmr, ltmr_nx;
    logic [3:0] rel, rel_nx, rr, rr_nx, ld_idx;
    logic [1:0] level_nx;
    logic [N_ENEMIES-1:0] mask, mask_nx;
    logic [16*N_ENEMIES-1:0] ctrl_nx;
    logic all_nx, adv, ld, lvl_step;
    logic [15:0] lfsr_q, lfsr_nx;
    ctrl_word_t word;
    logic [20:0] unused_bits;

    lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .frame_clk(frame_clk),
        .rst(rst),
        .adv(adv),
        .q(lfsr_q),
        .q_nx(lfsr_nx)
    );

    assign unused_bits = {lfsr_q, lfsr_nx[15:11]};
    assign word = make_word(level, lfsr_nx[10:0]);
    assign enemy_en = pause ? '0 : mask;
    assign lvl_step = (ltmr == LW'(LEVEL_FRAMES - 1));

    always_comb begin
        state_nx = state;
        cnt_nx = cnt;
        ltmr_nx = ltmr;
        level_nx = level;
        rel_nx = rel;
        rr_nx = rr;
        mask_nx = mask;
        all_nx = all_released;
        ctrl_nx = enemy_control;
        adv = 1'b0;
        ld = 1'b0;
        ld_idx = 4'd0;
        if (!run) begin
            state_nx = IDLE;
            cnt_nx = '0;
            ltmr_nx = '0;
            level_nx = 2'd0;
            rel_nx = 4'd0;
            rr_nx = 4'd0;
            mask_nx = '0;
            all_nx = 1'b0;
            ctrl_nx = '0;
        end else if (state == IDLE || !pause) begin
            // The start edge counts as the first active frame for the level timer.
            adv = 1'b1;
            ltmr_nx = lvl_step ? '0 : ltmr + 1'b1;
            level_nx = (lvl_step && level != 2'd3) ? level + 2'd1 : level;
            if (state == IDLE) begin
                ld = 1'b1;
                rel_nx = 4'd1;
                state_nx = (N_ENEMIES == 1) ? RUN : RAMP;
                all_nx = (N_ENEMIES == 1);
            end else if (state == RAMP) begin
                cnt_nx = (cnt == CW'(SPAWN_INTERVAL - 1)) ? '0 : cnt + 1'b1;
                if (cnt == CW'(SPAWN_INTERVAL - 1)) begin
                    ld = 1'b1;
                    ld_idx = rel;
                    rel_nx = rel + 4'd1;
                    if (rel == 4'(N_ENEMIES - 1)) begin
                        state_nx = RUN;
                        all_nx = 1'b1;
                    end
                end
            end else begin
                ld = 1'b1;
                ld_idx = rr;
                rr_nx = (rr == 4'(N_ENEMIES - 1)) ? 4'd0 : rr + 4'd1;
            end
            for (int k = 0; k < N_ENEMIES; k++)
                if (ld && ld_idx == 4'(k)) begin
                    ctrl_nx[16*k +: 16] = word;
                    mask_nx[k] = 1'b1;
                end
        end
    end

    always_ff @(posedge frame_clk or negedge rst)
        if (!rst) begin
            state <= IDLE;
            cnt <= '0;
            ltmr <= '0;
            level <= 2'd0;
            rel <= 4'd0;
            rr <= 4'd0;
            mask <= '0;
            all_released <= 1'b0;
            enemy_control <= '0;
        end else begin
            state <= state_nx;
            cnt <= cnt_nx;
            ltmr <= ltmr_nx;
            level <= level_nx;
            rel <= rel_nx;
            rr <= rr_nx;
            mask <= mask_nx;
            all_released <= all_nx;
            enemy_control <= ctrl_nx;
        end
endmodule

// File: tb/tb_enemy_spawner.sv
// tb_enemy_spawner: directed checks of release timing, level ramp, pause, run drop and reset
// on a default 4-enemy instance and a 1-enemy instance with a zero seed.
module tb_enemy_spawner;
    logic frame_clk = 1'b0;
    logic rst = 1'b0;
    logic run = 1'b0;
    logic pause = 1'b0;
    logic [63:0] ctrl0;
    logic [3:0] en0;
    logic [1:0] lvl0;
    logic all0;
    logic [15:0] ctrl1;
    logic [0:0] en1;
    logic [1:0] lvl1;
    logic all1;

    int nvec = 0;
    int nerr = 0;
    int a = 0;
    logic [15:0] m0 = 16'hACE1;
    logic [15:0] m1 = 16'h0001;
    logic [15:0] e0 [4];
    logic [15:0] e1;
    logic [3:0] emask;

    enemy_spawner dut0 (
        .frame_clk(frame_clk), .rst(rst), .run(run), .pause(pause),
        .enemy_control(ctrl0), .enemy_en(en0), .level(lvl0), .all_released(all0)
    );

    enemy_spawner #(.N_ENEMIES(1), .LFSR_SEED(16'h0000)) dut1 (
        .frame_clk(frame_clk), .rst(rst), .run(run), .pause(pause),
        .enemy_control(ctrl1), .enemy_en(en1), .level(lvl1), .all_released(all1)
    );

    always #5 frame_clk = ~frame_clk;

    function automatic logic [15:0] lstep(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    endfunction

    function automatic logic [15:0] wd(input logic [15:0] s, input logic [1:0] l);
        return {3'b000, l, s[10:0]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h (active frame %0d)", tag, obs, exp, a);
        end
    endtask

    task automatic tick();
        @(posedge frame_clk);
        #1;
    endtask

    task automatic clear_model();
        a = 0;
        emask = 4'b0000;
        e1 = 16'h0000;
        for (int k = 0; k < 4; k++) e0[k] = 16'h0000;
    endtask

    task automatic check_all();
        logic [1:0] lv;
        lv = (a >= 1800) ? 2'd3 : 2'(a / 600);
        chk("en0", 64'(en0), pause ? 64'd0 : 64'(emask));
        chk("ctrl0", ctrl0, {e0[3], e0[2], e0[1], e0[0]});
        chk("level0", 64'(lvl0), 64'(lv));
        chk("all0", 64'(all0), 64'(a >= 181));
        chk("en1", 64'(en1), 64'(!pause && a >= 1));
        chk("ctrl1", 64'(ctrl1), 64'(e1));
        chk("level1", 64'(lvl1), 64'(lv));
        chk("all1", 64'(all1), 64'(a >= 1));
    endtask

    // One unpaused frame with run high: enemy k is released on active frame 1+60k,
    // then from frame 182 one slot per frame is refreshed in round-robin order.
    task automatic active_edge();
        logic [1:0] lv;
        tick();
        a++;
        lv = (a - 1 >= 1800) ? 2'd3 : 2'((a - 1) / 600);
        m0 = lstep(m0);
        m1 = lstep(m1);
        for (int k = 0; k < 4; k++)
            if (a == 1 + 60 * k) begin
                e0[k] = wd(m0, lv);
                emask[k] = 1'b1;
            end
        if (a >= 182) e0[(a - 182) % 4] = wd(m0, lv);
        e1 = wd(m1, lv);
        check_all();
    endtask

    initial begin
        clear_model();
        #2 check_all();
        #10 rst = 1'b1;
        tick();
        check_all();

        run = 1'b1;
        active_edge();
        chk("first_word0", 64'(ctrl0[15:0]), 64'h0270);
        chk("first_word1", 64'(ctrl1), 64'h0400);
        chk("first_en0", 64'(en0), 64'b0001);
        while (a < 595) active_edge();

        pause = 1'b1;
        #1 chk("pause_en0_comb", 64'(en0), 64'd0);
        chk("pause_en1_comb", 64'(en1), 64'd0);
        for (int i = 0; i < 10; i++) begin
            tick();
            check_all();
        end
        pause = 1'b0;
        #1 chk("unpause_en0_comb", 64'(en0), 64'hF);
        while (a < 1850) active_edge();
        chk("level_sat", 64'(lvl0), 64'd3);

        #3 rst = 1'b0;
        run = 1'b0;
        clear_model();
        m0 = 16'hACE1;
        m1 = 16'h0001;
        #1 check_all();
        #1 rst = 1'b1;
        tick();
        check_all();

        run = 1'b1;
        active_edge();
        chk("reseed_word0", 64'(ctrl0[15:0]), 64'h0270);
        chk("reseed_word1", 64'(ctrl1), 64'h0400);
        while (a < 70) active_edge();
        chk("ramp_en0", 64'(en0), 64'b0011);

        run = 1'b0;
        pause = 1'b1;
        tick();
        clear_model();
        check_all();
        chk("drop_ctrl0", ctrl0, 64'd0);

        pause = 1'b0;
        run = 1'b1;
        for (int i = 0; i < 3; i++) active_edge();
        chk("restart_en0", 64'(en0), 64'b0001);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/enemy_spawner.md
Name: enemy_spawner

Overview:
Frame-rate scheduler sitting directly upstream of the enemy instances. It produces each enemy's 16-bit control word and its per-enemy enable.
- Enemies are released one at a time on a fixed frame interval.
- Each control word is re-randomised round-robin from a 16-bit LFSR, so every enemy respawn picks up a fresh lane, direction and speed.
- A frame-based timer raises the difficulty level, which drives each enemy's speed field.

Parameters:
N_ENEMIES, 4, number of enemy instances served (1..8)
SPAWN_INTERVAL, 60, frames between successive enemy releases during ramp-up (>=1)
LEVEL_FRAMES, 600, unpaused active frames per level step (>=1)
LFSR_SEED, 16'hACE1, LFSR reset value; a seed of 0 is replaced by 16'h0001

Ports:
frame_clk  input  1  frame-rate clock, one rising edge per video frame
rst  input  1  asynchronous reset, active-low (asserted when 0)
run  input  1  game active; 0 returns the block to IDLE
pause  input  1  freeze all enemies and all internal counters
enemy_control  output  16*N_ENEMIES  packed control words; enemy k uses bits [16k+15:16k]
enemy_en  output  N_ENEMIES  per-enemy enable; connects to each enemy's en input
level  output  2  current difficulty level, 0..3
all_released  output  1  high once every enemy has been enabled (state RUN)

Behaviour:
- Reset (rst=0, asynchronous) sets:
  - state=IDLE, lfsr=seed, level=0
  - enemy_en=0, enemy_control=0, all_released=0
  - interval counter, level timer, release index and round-robin index all 0
- All registers update on the rising edge of frame_clk.
- Control word format: {3'b000, level[1:0], lfsr_nx[10], lfsr_nx[9:0]}.
  - lfsr_nx is the LFSR value after the advance on the same edge.
  - Bits [9:0] are raw; the enemy applies its own mod 640.
- LFSR: 16-bit Galois, shift right; if lsb=1, XOR 16'hB400 into the shifted value.
  - Advances once per edge in RAMP or RUN when pause=0; holds otherwise.
  - Never reaches 0.
- States:
  - IDLE:
    - enemy_en=0; all counters held at 0.
    - run=1 → RAMP. On that edge: LFSR advances, control[0] is loaded, enemy_en[0]=1, release index=1.
    - If N_ENEMIES=1 the transition goes directly to RUN.
  - RAMP:
    - Each unpaused edge increments the interval counter.
    - When interval counter = SPAWN_INTERVAL-1: counter→0, enemy[release index] is loaded and enabled, index++.
    - When index reaches N_ENEMIES → RUN and all_released=1 on that same edge.
    - No refresh of already-released words in RAMP.
  - RUN:
    - Each unpaused edge loads control[rr] with a fresh word.
    - rr increments mod N_ENEMIES.
- Level timer:
  - Counts unpaused edges in RAMP/RUN.
  - At LEVEL_FRAMES-1 it wraps to 0 and level increments, saturating at 3.
  - The new level appears in words loaded from the following edge onward.
- pause=1 in RAMP/RUN:
  - enemy_en forced to all 0 combinationally from the registered mask.
  - The mask is retained; on un-pause the same enemies resume.
  - LFSR, timers and indices hold; state is unchanged.
- run=0 in RAMP/RUN:
  - → IDLE on the next edge.
  - enemy_en=0, enemy_control cleared to 0, level=0, all_released=0, counters cleared.
  - The LFSR keeps its value (not reseeded), so each game differs.
- Simultaneous events:
  - run=0 together with pause=1: run=0 wins.
  - A release and a level step on the same edge: the word uses the old level.
- Reset mid-operation: immediate return to reset values regardless of state.
- Latency: one frame_clk edge from a run/pause change to its effect on registered outputs. Pause gating of enemy_en is combinational.

Decomposition:
- Package enemy_pkg holds:
  - SCREEN_W=640 and SCREEN_H=480
  - control field positions: START_LSB=0, START_W=10, FLIP_BIT=10, SPEED_LSB=11, SPEED_W=2
  - LFSR_TAPS=16'hB400
  - typedef ctrl_word_t (logic [15:0])
  - spawner state enum {IDLE, RAMP, RUN}
- The same package is imported by the enemy block for field extraction.
- One sub-module, lfsr16: ports frame_clk, rst, adv, seed parameter, q, q_nx.

Test Plan:
1. Reset release, then run=1 with defaults → after the first edge: lfsr_nx=16'hE270, enemy_control[15:0]=16'h0270, enemy_en=4'b0001, state RAMP.
2. run held high → enemy_en=0011 at edge 61, 0111 at edge 121, 1111 with all_released=1 at edge 181. Words for enemies 1..3 are nonzero with bits [15:13]=0.
3. Run for 600 unpaused frames → level=1 at edge 600. Words loaded from edge 601 have bits [12:11]=01. Level holds at 3 after 1800+ frames.
4. In RUN, assert pause for 10 frames → enemy_en=0 immediately; lfsr, level and timers unchanged. On release, enemy_en=1111 and the LFSR sequence resumes from the held value.
5. Deassert run during RAMP with pause=1 on the same edge → IDLE, enemy_en=0, enemy_control=0, level=0. The next run=1 restarts the release at enemy 0 with the LFSR continuing.
6. Assert rst=0 mid-RUN between clock edges → outputs clear asynchronously before the next edge. The LFSR returns to 16'hACE1; with LFSR_SEED=0 it returns to 16'h0001.
